// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
//
// Shares one RGB LED between NREQ independent requesters and produces the three
// PWM drive signals for the iCE40 SB_RGBA_DRV hard LED driver.
//
// Arbitration is round-robin with a time-slice limit: an owner keeps the LED
// while it holds its request, but once it has held it for SLICE_CYCLES cycles
// and somebody else is waiting, ownership moves on to the next waiting
// requester. Colour and ownership changes only reach the PWM outputs on a
// PWM period boundary, so a running period is never cut short or stretched.
//
// Parameters
//   NREQ          number of requesters (2..8)
//   PWM_BITS      duty resolution per channel; period is 2**PWM_BITS cycles
//   SLICE_CYCLES  maximum hold time while others wait (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   req        per-requester level request, held while the LED is wanted
//   color      per-requester colour, slice i = {red, green, blue}
//              at [(i+1)*3*PWM_BITS-1 : i*3*PWM_BITS]
//   grant      one-hot (or zero) current owner, registered
//   busy       high while any requester owns the LED, registered
//   pwm_red    PWM output, connect to RGB1PWM, registered
//   pwm_green  PWM output, connect to RGB0PWM, registered
//   pwm_blue   PWM output, connect to RGB2PWM, registered
// -----------------------------------------------------------------------------
module rgb_led_arbiter #(
   parameter int NREQ         = 4,
   parameter int PWM_BITS     = 8,
   parameter int SLICE_CYCLES = 1200000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*3*PWM_BITS-1:0] color,
   output logic [NREQ-1:0]            grant,
   output logic                       busy,
   output logic                       pwm_red,
   output logic                       pwm_green,
   output logic                       pwm_blue
);

   // Index and countdown widths. The countdown only ever holds values up to
   // SLICE_CYCLES-1, so clog2(SLICE_CYCLES) bits are enough (1 bit minimum).
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
   localparam int CW = 3 * PWM_BITS;

   localparam logic [SW-1:0]       SLICE_LOAD = SW'(SLICE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] CNT_LAST   = '1;
   localparam logic [IW-1:0]       LAST_IDX   = IW'(NREQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t              state_reg, state_next;
   logic [IW-1:0]       owner_reg, owner_next;
   logic [IW-1:0]       ptr_reg, ptr_next;
   logic [SW-1:0]       slice_reg, slice_next;
   logic [NREQ-1:0]     grant_reg, grant_next;
   logic                busy_reg, busy_next;

   logic [PWM_BITS-1:0] cnt_reg;
   logic [PWM_BITS-1:0] duty_r_reg, duty_g_reg, duty_b_reg;
   logic                pwm_red_reg, pwm_green_reg, pwm_blue_reg;

   // ------------------------------------------------------------------------
   // Per-requester colour slices and owner decode
   // ------------------------------------------------------------------------
   logic [CW-1:0]   color_slice [NREQ];
   logic [NREQ-1:0] owner_onehot;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign color_slice[gi]  = color[gi*CW +: CW];
      assign owner_onehot[gi] = (owner_reg == IW'(gi));
      // Grant follows the next-state owner so it is registered alongside it.
      assign grant_next[gi]   = (state_next == OWNED) && (owner_next == IW'(gi));
   end

   // ------------------------------------------------------------------------
   // Round-robin search: first set bit of r at or after start, wrapping
   // modulo NREQ. Returns {found, index}.
   // ------------------------------------------------------------------------
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IW-1:0]   start);
      logic          found;
      logic [IW-1:0] idx;
      logic [IW-1:0] pos;
      found = 1'b0;
      idx   = '0;
      pos   = start;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && r[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
         pos = (pos == LAST_IDX) ? '0 : pos + 1'b1;
      end
      return {found, idx};
   endfunction

   logic [IW-1:0] owner_succ;
   logic [IW:0]   idle_pick;
   logic [IW:0]   preempt_pick;

   assign owner_succ   = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
   assign idle_pick    = rr_pick(req, ptr_reg);
   // The current owner is masked out so a preemption always hands over.
   assign preempt_pick = rr_pick(req & ~owner_onehot, owner_succ);

   // ------------------------------------------------------------------------
   // Arbiter FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         ptr_reg   <= '0;
         slice_reg <= '0;
         grant_reg <= '0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         ptr_reg   <= ptr_next;
         slice_reg <= slice_next;
         grant_reg <= grant_next;
         busy_reg  <= busy_next;
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      ptr_next   = ptr_reg;
      slice_next = slice_reg;

      unique case (state_reg)
         IDLE: begin
            if (idle_pick[IW]) begin
               owner_next = idle_pick[IW-1:0];
               slice_next = SLICE_LOAD;
               state_next = OWNED;
            end
         end
         OWNED: begin
            if (!req[owner_reg]) begin
               // Release has priority over slice expiry; the search for the
               // next owner restarts just past the releasing requester.
               state_next = IDLE;
               ptr_next   = owner_succ;
            end else if (slice_reg == '0) begin
               slice_next = SLICE_LOAD;
               if (preempt_pick[IW]) begin
                  owner_next = preempt_pick[IW-1:0];
               end
            end else begin
               slice_next = slice_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == OWNED);
   end

   // ------------------------------------------------------------------------
   // PWM counter, duty registers and registered compare
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Duties are latched only at the last count of a period, from the
   // registered owner/busy, so a period always runs with one fixed colour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_r_reg <= '0;
         duty_g_reg <= '0;
         duty_b_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
         if (busy_reg) begin
            duty_r_reg <= color_slice[owner_reg][CW-1 -: PWM_BITS];
            duty_g_reg <= color_slice[owner_reg][2*PWM_BITS-1 -: PWM_BITS];
            duty_b_reg <= color_slice[owner_reg][PWM_BITS-1 -: PWM_BITS];
         end else begin
            duty_r_reg <= '0;
            duty_g_reg <= '0;
            duty_b_reg <= '0;
         end
      end
   end

   // High for counts 0..duty-1; duty 0 is constantly low and full-on cannot
   // be reached, which is the intended range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_red_reg   <= 1'b0;
         pwm_green_reg <= 1'b0;
         pwm_blue_reg  <= 1'b0;
      end else begin
         pwm_red_reg   <= (cnt_reg < duty_r_reg);
         pwm_green_reg <= (cnt_reg < duty_g_reg);
         pwm_blue_reg  <= (cnt_reg < duty_b_reg);
      end
   end

   assign grant     = grant_reg;
   assign busy      = busy_reg;
   assign pwm_red   = pwm_red_reg;
   assign pwm_green = pwm_green_reg;
   assign pwm_blue  = pwm_blue_reg;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_arbiter
//
// Self-checking bench for rgb_led_arbiter (NREQ=4, PWM_BITS=8, SLICE_CYCLES=10).
// A behavioural model tracks owner / hold age / search pointer and the duty of
// each PWM period; a compare process checks every DUT output against it on
// each falling clock edge. Directed scenarios add literal expectations, then
// a randomized phase exercises the arbiter and colour paths.
// -----------------------------------------------------------------------------
module tb_rgb_led_arbiter;

   localparam int N      = 4;
   localparam int PW     = 8;
   localparam int S      = 10;
   localparam int PERIOD = 1 << PW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*3*PW-1:0] color = '0;
   logic [N-1:0]    grant;
   logic            busy;
   logic            pwm_red;
   logic            pwm_green;
   logic            pwm_blue;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rgb_led_arbiter #(
      .NREQ         (N),
      .PWM_BITS     (PW),
      .SLICE_CYCLES (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .color     (color),
      .grant     (grant),
      .busy      (busy),
      .pwm_red   (pwm_red),
      .pwm_green (pwm_green),
      .pwm_blue  (pwm_blue)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   int m_owner = -1;    // -1 means nobody owns the LED
   int m_ptr   = 0;
   int m_age   = 0;     // cycles the current owner has held the LED
   int m_cyc   = 0;     // clock edges since reset release
   int m_dr = 0, m_dg = 0, m_db = 0;
   logic [N-1:0] e_grant = '0;
   logic e_busy = 1'b0, e_r = 1'b0, e_g = 1'b0, e_b = 1'b0;

   function automatic int first_set(input logic [N-1:0] r, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (start + k) % N;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   initial begin
      forever begin
         int ph;
         int w;
         @(posedge clk or posedge rst);
         if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_cyc = 0;
            m_dr = 0; m_dg = 0; m_db = 0;
            e_grant = '0; e_busy = 0; e_r = 0; e_g = 0; e_b = 0;
         end else begin
            ph  = m_cyc % PERIOD;
            e_r = (ph < m_dr);
            e_g = (ph < m_dg);
            e_b = (ph < m_db);
            if (ph == PERIOD - 1) begin
               if (m_owner >= 0) begin
                  m_dr = int'(color[m_owner*3*PW + 2*PW +: PW]);
                  m_dg = int'(color[m_owner*3*PW + PW +: PW]);
                  m_db = int'(color[m_owner*3*PW +: PW]);
               end else begin
                  m_dr = 0; m_dg = 0; m_db = 0;
               end
            end
            if (m_owner < 0) begin
               if (req != '0) begin
                  m_owner = first_set(req, m_ptr, -1);
                  m_age   = 1;
               end
            end else if (!req[m_owner]) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end else if (m_age == S) begin
               w = first_set(req, m_owner + 1, m_owner);
               if (w >= 0) m_owner = w;
               m_age = 1;
            end else begin
               m_age++;
            end
            m_cyc++;
            e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            e_busy  = (m_owner >= 0);
         end
      end
   end

   // Compare process: every cycle outside reset
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("model_grant", 32'(grant), 32'(e_grant));
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_pwm_red", 32'(pwm_red), 32'(e_r));
            check("model_pwm_green", 32'(pwm_green), 32'(e_g));
            check("model_pwm_blue", 32'(pwm_blue), 32'(e_b));
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers: inputs change 2 time units after the rising edge
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_color(input int idx, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
      color[idx*3*PW +: 3*PW] = {r, g, b};
   endtask

   int cnt_r, cnt_g, cnt_b, nonzero, guard;
   logic [N-1:0] rr_seq [3];

   initial begin
      rr_seq[0] = 4'b0001;
      rr_seq[1] = 4'b0010;
      rr_seq[2] = 4'b1000;

      // 1. Reset defaults
      for (int i = 0; i < 5; i++) step();
      rst = 1'b0;
      nonzero = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (grant != '0 || busy || pwm_red || pwm_green || pwm_blue) nonzero++;
      end
      check("reset_idle_outputs", 32'(nonzero), 32'd0);
      $display("reset defaults: %0d idle cycles with active output", nonzero);

      // 2. Single owner duty
      set_color(2, 8'h80, 8'h01, 8'h00);
      req = 4'b0100;
      step();
      check("single_grant", 32'(grant), 32'h4);
      $display("single owner: grant=%b", grant);
      for (int i = 0; i < 300; i++) step();
      cnt_r = 0; cnt_g = 0; cnt_b = 0;
      for (int i = 0; i < PERIOD; i++) begin
         step();
         cnt_r += int'(pwm_red); cnt_g += int'(pwm_green); cnt_b += int'(pwm_blue);
      end
      check("duty_red_128", 32'(cnt_r), 32'd128);
      check("duty_green_1", 32'(cnt_g), 32'd1);
      check("duty_blue_0", 32'(cnt_b), 32'd0);
      $display("single owner period: red=%0d green=%0d blue=%0d", cnt_r, cnt_g, cnt_b);
      req = '0;
      step();

      // 3. Round-robin preemption from a fresh reset (ptr = 0)
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      set_color(0, 8'h10, 8'h20, 8'h30);
      set_color(1, 8'h05, 8'hF0, 8'h00);
      set_color(3, 8'h40, 8'h10, 8'h00);
      req = 4'b1011;
      for (int i = 0; i < 60; i++) begin
         step();
         check("rr_grant", 32'(grant), 32'(rr_seq[(i / 10) % 3]));
      end
      $display("round robin: 60 cycles of grant sequence observed");

      // 4. Release order
      guard = 0;
      while (grant != 4'b0010 && guard < 40) begin
         step();
         guard++;
      end
      check("wait_owner1_bound", 32'(grant == 4'b0010), 32'd1);
      req = 4'b1001;
      step();
      check("release_gap", 32'(grant), 32'h0);
      step();
      check("release_next", 32'(grant), 32'h8);
      $display("release order: grant=%b after one idle cycle", grant);

      // 5. Glitch-free colour change at cnt = 100
      req = 4'b1000;
      for (int i = 0; i < 600; i++) step();
      guard = 0;
      while ((m_cyc % PERIOD) != 100 && guard < 2 * PERIOD) begin
         step();
         guard++;
      end
      check("wait_cnt100_bound", 32'((m_cyc % PERIOD) == 100), 32'd1);
      set_color(3, 8'hC0, 8'h10, 8'h00);
      cnt_r = 0;
      for (int i = 0; i < 155; i++) begin
         step();
         cnt_r += int'(pwm_red);
      end
      check("old_duty_rest_of_period", 32'(cnt_r), 32'd0);
      cnt_r = 0;
      for (int i = 0; i < PERIOD; i++) begin
         step();
         cnt_r += int'(pwm_red);
      end
      check("new_duty_next_period", 32'(cnt_r), 32'd192);
      $display("colour change: next period red high %0d cycles", cnt_r);

      // 6. Async reset mid-PWM
      guard = 0;
      while (!pwm_red && guard < 2 * PERIOD) begin
         step();
         guard++;
      end
      check("wait_red_high_bound", 32'(pwm_red), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_pwm_red", 32'(pwm_red), 32'd0);
      check("async_rst_grant", 32'(grant), 32'h0);
      check("async_rst_busy", 32'(busy), 32'd0);
      $display("async reset: pwm_red=%b grant=%b", pwm_red, grant);
      step(); step();
      rst = 1'b0;

      // Randomized phase
      for (int i = 0; i < N; i++) set_color(i, 8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 4000; i++) begin
         step();
         if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0)
            set_color($urandom_range(0, N - 1), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      $display("random phase: 4000 cycles");

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the single on-board RGB LED between several independent requesters (status logic, error flags, user cores) and generates the three PWM drive signals for the iCE40 `SB_RGBA_DRV` hard LED driver. Arbitration is round-robin with a time-slice limit, so one requester cannot starve the others. Colour changes are applied only on PWM period boundaries, which keeps the LED glitch-free. The block sits between the requesting cores and the `SB_RGBA_DRV` instance in `top`.

## Interface
- `NREQ`, 4: number of requesters, from 2 to 8.
- `PWM_BITS`, 8: duty resolution per channel. The PWM period is 2^PWM_BITS clock cycles.
- `SLICE_CYCLES`, 1200000: maximum hold time, in cycles, while others wait. The default is 100 ms at 12 MHz. Must be ≥ 1.

- `clk`  in  1  system clock, 12 MHz oscillator.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request per requester, level-sensitive, held while the LED is wanted.
- `color`  in  NREQ*3*PWM_BITS  per-requester colour. Slice i is `{red, green, blue}` at bits [(i+1)*3*PWM_BITS-1 : i*3*PWM_BITS].
- `grant`  out  NREQ  one-hot or zero. Marks the current owner. Registered.
- `busy`  out  1  high while any requester owns the LED. Registered.
- `pwm_red`, `pwm_green`, `pwm_blue`  out  1 each  PWM outputs. Wire them to `RGB1PWM`, `RGB0PWM` and `RGB2PWM` respectively. Registered.

## Operation
- Arbiter FSM states: IDLE, OWNED. Registers:
  - `owner` (index)
  - `ptr` (round-robin start)
  - `slice` (countdown)
- **IDLE:**
  - If `req` is zero, stay in IDLE.
  - Otherwise pick the first set `req` bit searching from `ptr` upward, wrapping modulo NREQ.
  - Set `owner`, assert `grant[owner]` and `busy`, load `slice = SLICE_CYCLES-1`, and go to OWNED.
- **OWNED, checked in priority order:**
  1. If `req[owner]` = 0: release. Clear `grant` and `busy`, set `ptr = (owner+1) mod NREQ`, go to IDLE. Exactly one idle cycle follows before the next grant.
  2. Else if `slice` = 0 and some other `req` is set: preempt. Grant the first set `req` searching from `owner+1`, wrapping and excluding `owner`. Reload `slice`. No gap cycle; `grant` moves in one edge and `busy` stays high.
  3. Else if `slice` = 0 and no other `req` is set: reload `slice` and keep the owner.
  4. Otherwise decrement `slice`.
- **PWM counter** `cnt`, PWM_BITS wide:
  - Free-running; increments every cycle and wraps from 2^PWM_BITS-1 to 0.
- **Duty registers** `duty_r`, `duty_g`, `duty_b`:
  - Load only in the cycle where `cnt` = 2^PWM_BITS-1.
  - Value loaded: the owner's `color` slice if `busy`, else 0.
  - Colour changes and ownership changes mid-period never alter the running period.
- **Outputs:**
  - Each cycle, `pwm_x <= (cnt < duty_x)`, an unsigned compare.
  - Duty 0 gives output constantly low.
  - Duty D gives D high cycles per period, contiguous from `cnt` = 0.
  - Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS. 100 % on is not supported.

## Timing
- **Reset values** (applied asynchronously on `rst` high):
  - 0: `grant`, `busy`, all `pwm_*`, `cnt`, all `duty_*`, `ptr`, `owner`, `slice`.
  - FSM state: IDLE.
- **Grant latency:** `req` sampled at edge k in IDLE gives `grant` high after edge k.
- **Release latency:** `req[owner]` low sampled at edge k gives `grant` low after edge k.
- **Colour latency:** new duty takes effect at the first `cnt` wrap after the change.
  - `pwm_x` lags `cnt`/`duty` by one cycle, due to the registered compare.
  - Worst case, `color` to visible output is 2^PWM_BITS+1 cycles.
- **Slice:** with two requesters continuously asserted, ownership alternates every SLICE_CYCLES cycles.
- **Boundary cases:**
  - All `req` rise together from reset (`ptr` = 0): requester 0 wins.
  - Owner drops `req` in the cycle `slice` reaches 0: release wins, and the next grant comes from IDLE.
  - Release and a `cnt` wrap in the same cycle: duty loads 0 if `busy` was already low at that edge, else the owner colour. The decision uses registered `busy`/`owner`.
  - NREQ = 2 with `SLICE_CYCLES` = 1: ownership toggles every cycle while both are requesting.
  - `rst` asserted mid-period: outputs go low immediately. After deassertion, the first duty load happens at `cnt` = 2^PWM_BITS-1.

## Test plan
1. **Reset defaults.** Hold `rst` for 5 cycles, then release with `req` = 0. Required: `grant` = 0, `busy` = 0 and `pwm_*` = 0 for 1000 cycles.
2. **Single owner duty.** Assert `req[2]` with colour `{0x80, 0x01, 0x00}`. Required: `grant` = 4'b0100 one cycle later. In every full period after the first wrap, `pwm_red` is high exactly 128 of 256 cycles, `pwm_green` exactly 1 cycle, and `pwm_blue` never.
3. **Round-robin preemption.** Use `SLICE_CYCLES` = 10 and hold `req` = 4'b1011 constantly. Required: `grant` sequence 0001, 0010, 1000, 0001, …, each held 10 cycles, with no zero-gap cycles.
4. **Release order.** Owner 1 drops `req` while `req[0]` and `req[3]` are held. Required: one cycle of `grant` = 0, then `grant` = 4'b1000 (search starts at `ptr` = 2).
5. **Glitch-free colour change.** Change the owner's colour at `cnt` = 100. Required: the current period still uses the old duty, and the new duty applies from `cnt` = 0 of the next period.
6. **Async reset mid-PWM.** Assert `rst` while `pwm_red` is high. Required: `pwm_red` is low before the next clock edge and `grant` = 0.
